// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 single-precision converter with valid/ready backpressure.
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module itof_pipe #(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] x,
  input  logic          is_unsigned,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   y,
  output logic          inexact
);

  localparam int PW = 7;

  logic          adv;
  logic          v1, v2;
  logic          s1_sign, s1_zero;
  logic [IW-1:0] s1_mag;
  logic          s2_sign, s2_zero;
  logic [IW-2:0] s2_norm;
  logic [7:0]    s2_exp;

  // Leading-one search and normalisation shift for S2
  logic [PW-1:0] lead_pos;
  logic [PW-1:0] shamt;
  logic [IW-2:0] norm_lo;

  // S3 rounding and packing
  logic [IW+22:0] wide;
  logic [22:0]    frac;
  logic           guard, sticky;
  logic [22:0]    frac_r;
  logic [7:0]     exp_r;
  logic [31:0]    y_next;
  logic           inexact_next;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IW; i++) begin
      if (s1_mag[i]) lead_pos = PW'(i);
    end
    shamt   = PW'(IW - 1) - lead_pos;
    norm_lo = s1_mag[IW-2:0] << shamt;
  end

  always_comb begin
    // Bits below the leading one, padded so narrow IW still yields a 23-bit fraction
    wide   = {s2_norm, 24'b0};
    frac   = wide[IW+22:IW];
    guard  = wide[IW-1];
    sticky = |wide[IW-2:0];
`ifdef ITOF_RNE_EN
    begin
      logic        inc;
      logic [23:0] sum;
      inc    = guard & (sticky | frac[0]);
      sum    = {1'b0, frac} + 24'(inc);
      frac_r = sum[22:0];
      exp_r  = s2_exp + 8'(sum[23]);
    end
`else
    frac_r = frac;
    exp_r  = s2_exp;
`endif
    if (s2_zero) begin
      y_next       = 32'h0000_0000;
      inexact_next = 1'b0;
    end else begin
      y_next       = {s2_sign, exp_r, frac_r};
      inexact_next = guard | sticky;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y         <= 32'h0000_0000;
      inexact   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        y       <= y_next;
        inexact <= inexact_next;
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_sign <= x[IW-1] & ~is_unsigned;
      s1_mag  <= (x[IW-1] & ~is_unsigned) ? (~x + IW'(1)) : x;
      s1_zero <= (x == '0);
    end
    if (adv && v1) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_norm <= norm_lo;
      s2_exp  <= 8'd127 + 8'(lead_pos);
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe (IW=32): arithmetic reference model with scoreboard,
// directed corner values, backpressure, mid-stream reset and randomized traffic.
module tb_itof_pipe;

  localparam int IW = 32;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] x;
  logic          is_unsigned;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   y;
  logic          inexact;

  int n_total = 0;
  int n_pass  = 0;
  logic rand_or = 1'b0;

  logic [32:0] sb[$];
  logic        hold = 1'b0;
  logic [31:0] hold_y;
  logic        hold_i;

  itof_pipe #(.IW(IW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .is_unsigned(is_unsigned), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input logic ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference: {inexact, y} from the magnitude's leading-one position and a remainder compare
  function automatic logic [32:0] model(input logic [IW-1:0] xv, input logic u);
    logic        s;
    logic [63:0] mag, mant, rem, half;
    int          p, sh;
    logic [7:0]  e;
    logic        inx;
    s   = xv[IW-1] & ~u;
    mag = 64'(xv);
    if (s) begin
      for (int i = IW; i < 64; i++) mag[i] = 1'b1;
      mag = -mag;
    end
    if (mag == 64'd0) return 33'd0;
    p = 63;
    while (!mag[p]) p--;
    if (p <= 23) begin
      mant = mag << (23 - p);
      inx  = 1'b0;
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
`ifdef ITOF_RNE_EN
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
`endif
    end
    e = 8'(127 + p);
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 8'd1;
    end
    return {inx, s, e, mant[22:0]};
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      hold = 1'b0;
    end else begin
      chk(in_ready == (!out_valid || out_ready), "in_ready_adv", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold)
        chk({out_valid, inexact, y} == {1'b1, hold_i, hold_y}, "stall_stable",
            64'({out_valid, inexact, y}), 64'({1'b1, hold_i, hold_y}));
      hold   = out_valid && !out_ready;
      hold_y = y;
      hold_i = inexact;
      if (out_valid && out_ready) begin
        chk(sb.size() != 0, "stale_output", 64'(y), 64'(0));
        if (sb.size() != 0) begin
          logic [32:0] e;
          e = sb.pop_front();
          chk({inexact, y} == e, "result", 64'({inexact, y}), 64'(e));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(x, is_unsigned));
    end
  end

  always @(posedge clk) begin
    if (rand_or) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [IW-1:0] xv, input logic u);
    int n = 0;
    in_valid = 1'b1;
    x = xv;
    is_unsigned = u;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(n < 200, "send_timeout", 64'(n), 64'(200));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    in_valid = 1'b0;
    x = '0;
    is_unsigned = 1'b0;
    out_ready = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
    chk(y == 32'h0, "rst_y", 64'(y), 64'(0));
    chk(inexact == 1'b0, "rst_inexact", 64'(inexact), 64'(0));
    chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // Hand-computed values that pin the reference model
    chk(model(32'h0000_0001, 1'b0) == {1'b0, 32'h3F80_0000}, "pin_one", 64'(model(32'h1, 1'b0)), 64'h3F80_0000);
    chk(model(32'h0000_0000, 1'b0) == 33'd0, "pin_zero", 64'(model(32'h0, 1'b0)), 64'h0);
    chk(model(32'h8000_0000, 1'b0) == {1'b0, 32'hCF00_0000}, "pin_min", 64'(model(32'h8000_0000, 1'b0)), 64'hCF00_0000);
    chk(model(32'hFFFF_FFFF, 1'b0) == {1'b0, 32'hBF80_0000}, "pin_m1", 64'(model(32'hFFFF_FFFF, 1'b0)), 64'hBF80_0000);
    chk(model(32'h0000_0002, 1'b0) == {1'b0, 32'h4000_0000}, "pin_two", 64'(model(32'h2, 1'b0)), 64'h4000_0000);
    chk(model(32'h0000_0003, 1'b0) == {1'b0, 32'h4040_0000}, "pin_three", 64'(model(32'h3, 1'b0)), 64'h4040_0000);
    chk(model(32'h0100_0001, 1'b0) == {1'b1, 32'h4B80_0000}, "pin_tie_dn", 64'(model(32'h0100_0001, 1'b0)), 64'h1_4B80_0000);
`ifdef ITOF_RNE_EN
    chk(model(32'hFFFF_FFFF, 1'b1) == {1'b1, 32'h4F80_0000}, "pin_umax", 64'(model(32'hFFFF_FFFF, 1'b1)), 64'h1_4F80_0000);
    chk(model(32'h0100_0003, 1'b0) == {1'b1, 32'h4B80_0002}, "pin_tie_up", 64'(model(32'h0100_0003, 1'b0)), 64'h1_4B80_0002);
`else
    chk(model(32'hFFFF_FFFF, 1'b1) == {1'b1, 32'h4F7F_FFFF}, "pin_umax", 64'(model(32'hFFFF_FFFF, 1'b1)), 64'h1_4F7F_FFFF);
    chk(model(32'h0100_0003, 1'b0) == {1'b1, 32'h4B80_0001}, "pin_tie_up", 64'(model(32'h0100_0003, 1'b0)), 64'h1_4B80_0001);
`endif

    @(posedge clk);
    #1;
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    send(32'h0100_0001, 1'b0);
    send(32'h0100_0003, 1'b0);
    send(32'h8000_0000, 1'b1);
    send(32'h00FF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    drain();

    // Backpressure: 1, 2, 3 back to back, then stall the first result for 5 cycles
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'(0));
      chk(out_valid == 1'b1, "bp_out_valid", 64'(out_valid), 64'(1));
      chk(y == 32'h3F80_0000, "bp_y", 64'(y), 64'h3F80_0000);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk(y == 32'h3F80_0000, "bp_first", 64'(y), 64'h3F80_0000);
    @(negedge clk);
    chk(y == 32'h4000_0000, "bp_second", 64'(y), 64'h4000_0000);
    @(negedge clk);
    chk(y == 32'h4040_0000, "bp_third", 64'(y), 64'h4040_0000);
    drain();

    // Mid-stream reset with three transactions in flight
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    #1 rstn = 1'b0;
    #1;
    chk(out_valid == 1'b0, "rst_mid_drop", 64'(out_valid), 64'(0));
    chk(in_ready == 1'b1, "rst_mid_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_no_stale", 64'(out_valid), 64'(0));
    in_valid = 1'b1;
    x = 32'd5;
    is_unsigned = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk(out_valid == 1'b0, "lat_c1", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "lat_c2", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk(out_valid == 1'b1, "lat_c3", 64'(out_valid), 64'(1));
    chk(y == 32'h40A0_0000, "lat_y", 64'(y), 64'h40A0_0000);
    drain();

    // Randomized traffic with random backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [IW-1:0] xv;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0: xv = IW'($urandom) >> $urandom_range(0, IW - 1);
        1: xv = {IW'($urandom) >> $urandom_range(0, 8)} | IW'(32'h0100_0000);
        2: xv = (IW'($urandom_range(1, 255)) << $urandom_range(0, 24)) | IW'($urandom_range(0, 1));
        default: xv = IW'($urandom);
      endcase
      send(xv, 1'($urandom_range(0, 1)));
    end
    rand_or = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
